// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: loads win, losing ALU writes wait in an in-order queue.
// Define WB_PERF_EN to add the stall_cycles and kill_count performance counters.
module wb_port_arbiter #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          alu_valid,
   input  logic [4:0]    alu_rd,
   input  logic [31:0]   alu_data,
   output logic          alu_ready,
   input  logic          mem_valid,
   input  logic [4:0]    mem_rd,
   input  logic [31:0]   mem_data,
   output logic          wb_en,
   output logic [4:0]    wb_rd,
   output logic [31:0]   wb_data,
   output logic [31:0]   pending_mask,
   output logic [CW-1:0] q_count
`ifdef WB_PERF_EN
   ,
   output logic [31:0]   stall_cycles,
   output logic [31:0]   kill_count
`endif
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [4:0]       q_rd_reg   [DEPTH];
   logic [31:0]      q_data_reg [DEPTH];
   logic [DEPTH-1:0] q_live_reg, q_live_next;
   logic [DEPTH-1:0] kill_vec;
   logic [PW-1:0]    head_reg, head_next, tail_reg, tail_next;
   logic [CW-1:0]    count_reg, count_next;
   logic             wb_en_reg, wb_en_next;
   logic [4:0]       wb_rd_reg, wb_rd_next;
   logic [31:0]      wb_data_reg, wb_data_next;
   logic             accept, push, pop;

   // Space is judged on registered occupancy only, so a pop never frees a slot for the same cycle.
   assign alu_ready = (count_reg < DEPTH_C);
   assign accept    = alu_valid && alu_ready;

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign kill_vec[gi] = mem_valid && q_live_reg[gi] && (q_rd_reg[gi] == mem_rd);
         // A same-cycle push lands in a free slot and is younger than the load, so it beats the kill.
         assign q_live_next[gi] = (push && tail_reg == PW'(gi)) ? (alu_rd != 5'd0) :
                                  (pop && head_reg == PW'(gi))  ? 1'b0 :
                                  (q_live_reg[gi] && !kill_vec[gi]);
      end
   endgenerate

   always_comb begin
      wb_en_next   = 1'b0;
      wb_rd_next   = wb_rd_reg;
      wb_data_next = wb_data_reg;
      push         = 1'b0;
      pop          = 1'b0;
      if (mem_valid) begin
         wb_en_next   = (mem_rd != 5'd0);
         wb_rd_next   = mem_rd;
         wb_data_next = mem_data;
         push         = accept;
      end else if (count_reg != '0) begin
         pop        = 1'b1;
         push       = accept;
         wb_en_next = q_live_reg[head_reg];
         if (q_live_reg[head_reg]) begin
            wb_rd_next   = q_rd_reg[head_reg];
            wb_data_next = q_data_reg[head_reg];
         end
      end else if (alu_valid) begin
         wb_en_next   = (alu_rd != 5'd0);
         wb_rd_next   = alu_rd;
         wb_data_next = alu_data;
      end
   end

   always_comb begin
      head_next  = pop  ? head_reg + PW'(1) : head_reg;
      tail_next  = push ? tail_reg + PW'(1) : tail_reg;
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + CW'(1);
      else if (pop && !push)
         count_next = count_reg - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_live_reg  <= '0;
         head_reg    <= '0;
         tail_reg    <= '0;
         count_reg   <= '0;
         wb_en_reg   <= 1'b0;
         wb_rd_reg   <= '0;
         wb_data_reg <= '0;
      end else begin
         q_live_reg  <= q_live_next;
         head_reg    <= head_next;
         tail_reg    <= tail_next;
         count_reg   <= count_next;
         wb_en_reg   <= wb_en_next;
         wb_rd_reg   <= wb_rd_next;
         wb_data_reg <= wb_data_next;
      end
   end

   // Payload storage needs no reset; liveness alone decides whether an entry matters.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         q_rd_reg[tail_reg]   <= alu_rd;
         q_data_reg[tail_reg] <= alu_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_live_reg[i])
            pending_mask[q_rd_reg[i]] = 1'b1;
      end
      pending_mask[0] = 1'b0;
   end

   assign wb_en   = wb_en_reg;
   assign wb_rd   = wb_rd_reg;
   assign wb_data = wb_data_reg;
   assign q_count = count_reg;

`ifdef WB_PERF_EN
   logic [31:0]   stall_cycles_reg;
   logic [31:0]   kill_count_reg;
   logic [CW-1:0] kill_num;

   always_comb begin
      kill_num = '0;
      for (int i = 0; i < DEPTH; i++)
         kill_num = kill_num + CW'(kill_vec[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_reg <= '0;
         kill_count_reg   <= '0;
      end else begin
         if (alu_valid && !alu_ready)
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         kill_count_reg <= kill_count_reg + 32'(kill_num);
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign kill_count   = kill_count_reg;
`endif
endmodule
